// File: rtl/fetch_mem_unit_if.sv
// Memory-side handshake of the fetch/memory unit: one outstanding access,
// completed by a single-cycle mem_ready strobe.
interface fetch_mem_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/fetch_mem_unit.sv
// Multicycle-CPU fetch/memory front end: PC register, IR/MDR loading and a
// single-outstanding memory access sequencer with timeout and sticky error.
//
// state    | meaning
// S_IDLE   | no access in flight; a single request bit launches one
// S_ACCESS | access presented on the bus, waiting for mem_ready or timeout
module fetch_mem_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   fetch_mem_unit_if.master        mem,
   input  logic                    i_iord,
   input  logic                    i_ir_write,
   input  logic                    i_mem_read,
   input  logic                    i_mem_write,
   input  logic                    i_pc_write,
   input  logic                    i_pc_write_cond,
   input  logic [1:0]              i_pc_source,
   input  logic [31:0]             i_alu_result,
   input  logic [31:0]             i_alu_out,
   input  logic                    i_zero,
   input  logic [31:0]             i_wr_data,
   output logic [31:0]             o_pc,
   output logic [31:0]             o_instr,
   output logic [31:0]             o_mdr,
   output logic [5:0]              o_op_code,
   output logic                    o_busy,
   output logic                    o_err
);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;
   typedef enum logic [1:0] {K_IR, K_RD, K_WR} kind_t;

   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

   state_t      r_state, w_next;
   kind_t       r_kind;
   logic [31:0] r_addr, r_wdata, r_pc, r_instr, r_mdr;
   logic [7:0]  r_cnt;
   logic        r_err;

   logic        w_req, w_onehot, w_launch, w_multi, w_done, w_abort, w_cnt_lt;
   logic        w_busy, w_pc_en, w_mem_req, w_mem_we;
   logic [31:0] w_addr_sel, w_pc_next;
   kind_t       w_kind;

   assign w_req      = i_ir_write | i_mem_read | i_mem_write;
   assign w_onehot   = ({i_ir_write, i_mem_read, i_mem_write} == 3'b100) ||
                       ({i_ir_write, i_mem_read, i_mem_write} == 3'b010) ||
                       ({i_ir_write, i_mem_read, i_mem_write} == 3'b001);
   assign w_launch   = (r_state == S_IDLE) && w_onehot;
   assign w_multi    = (r_state == S_IDLE) && w_req && !w_onehot;
   assign w_cnt_lt   = r_cnt < TO_CNT;
   assign w_done     = (r_state == S_ACCESS) && mem.mem_ready;
   assign w_abort    = (r_state == S_ACCESS) && !mem.mem_ready && !w_cnt_lt;
   assign w_addr_sel = i_iord ? i_alu_out : r_pc;
   assign w_kind     = i_ir_write ? K_IR : (i_mem_read ? K_RD : K_WR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_launch) w_next = S_ACCESS;
         S_ACCESS: if (w_done || w_abort) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_mem_req = 1'b0;
      w_mem_we  = 1'b0;
      w_busy    = 1'b0;
      case (r_state)
         S_IDLE:   w_busy = w_req;
         S_ACCESS: begin
            w_mem_req = 1'b1;
            w_mem_we  = (r_kind == K_WR);
            w_busy    = !mem.mem_ready && w_cnt_lt;
         end
         default: ;
      endcase
   end

   // Access datapath; a misaligned address flags err but the aligned word is still accessed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_kind  <= K_IR;
         r_cnt   <= 8'h0;
         r_instr <= 32'h0;
         r_mdr   <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         if (w_launch) begin
            r_addr  <= w_addr_sel;
            r_wdata <= i_wr_data;
            r_kind  <= w_kind;
            r_cnt   <= 8'h0;
            if (w_addr_sel[1:0] != 2'b00) r_err <= 1'b1;
         end
         if (w_multi || w_abort) r_err <= 1'b1;
         if ((r_state == S_ACCESS) && !mem.mem_ready && w_cnt_lt) r_cnt <= r_cnt + 8'd1;
         if (w_done && (r_kind == K_IR)) r_instr <= mem.mem_rdata;
         if (w_done && (r_kind == K_RD)) r_mdr   <= mem.mem_rdata;
      end
   end

   assign w_pc_en = (i_pc_write || (i_pc_write_cond && i_zero)) && !w_busy;

   always_comb begin
      w_pc_next = r_pc;
      case (i_pc_source)
         2'b00:   w_pc_next = i_alu_result;
         2'b01:   w_pc_next = i_alu_out;
         2'b10:   w_pc_next = {r_pc[31:28], r_instr[25:0], 2'b00};
         default: w_pc_next = r_pc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_pc <= RESET_PC;
      else if (w_pc_en) r_pc <= w_pc_next;
   end

   assign mem.mem_req   = w_mem_req;
   assign mem.mem_we    = w_mem_we;
   assign mem.mem_addr  = {r_addr[31:2], 2'b00};
   assign mem.mem_wdata = r_wdata;

   assign o_pc      = r_pc;
   assign o_instr   = r_instr;
   assign o_mdr     = r_mdr;
   assign o_op_code = r_instr[31:26];
   assign o_busy    = w_busy;
   assign o_err     = r_err;

endmodule
